multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control FSM for the multi-cycle RV32I-subset core. It sequences instruction fetch, decode, execute, memory access and writeback over a shared ALU and a single shared memory port, and drives every mux select and write strobe in the datapath. The datapath sign-extends immediates directly from the instruction opcode, so this block does not produce an immediate-format select. Memory accesses use a valid/ready wait-state handshake.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- Opcode  in  7  instruction register bits [6:0]
- Funct3  in  3  instruction register bits [14:12]
- Funct7b5  in  1  instruction register bit 30
- Zero  in  1  ALU result equals zero
- MemReady  in  1  memory completes the current access this cycle
- MemRead  out  1  read request; held until MemReady
- MemWrite  out  1  write request; held until MemReady
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load the instruction register and OldPC
- PCWrite  out  1  load PC from the result bus
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = SignImm, 10 = constant 4
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ResultSrc  out  2  result bus select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult
- Illegal  out  1  sticky trap flag
- State  out  4  current state, debug only

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=15.
- All outputs are combinational from the state and inputs. Any output not listed for a state is 0.
- FETCH
  - Outputs: MemRead=1, AdrSrc=0, A=00, B=10, add, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Goes to DECODE when MemReady=1; otherwise stays in FETCH.
- DECODE
  - Outputs: A=01, B=01, add. This computes the branch/jump target into ALUOut.
  - Next state by Opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other opcode → TRAP
- MEMADR
  - Outputs: A=10, B=01, add.
  - Goes to MEMREAD if Opcode[5]=0, otherwise MEMWRITE.
- MEMREAD
  - Outputs: MemRead=1, AdrSrc=1.
  - Goes to MEMWB when MemReady=1.
- MEMWB
  - Outputs: ResultSrc=01, RegWrite=1.
  - Next state: FETCH.
- MEMWRITE
  - Outputs: MemWrite=1, AdrSrc=1.
  - Goes to FETCH when MemReady=1.
- EXECR
  - Outputs: A=10, B=00, decoded ALU op.
  - Next state: ALUWB.
- EXECI
  - Outputs: A=10, B=01, decoded ALU op.
  - Next state: ALUWB.
- ALUWB
  - Outputs: ResultSrc=00, RegWrite=1.
  - Next state: FETCH.
- BRANCH
  - Outputs: A=10, B=00, sub, ResultSrc=00.
  - PCWrite = Zero when Funct3=000 (beq).
  - PCWrite = !Zero when Funct3=001 (bne).
  - Next state: FETCH.
- JAL
  - Outputs: A=01, B=10, add, ResultSrc=00, PCWrite=1.
  - Next state: ALUWB, which writes the link value.
- ALU decode, used in EXECR and EXECI:
  - Funct3=000: add. It is sub only in EXECR with Funct7b5=1.
  - Funct3=010: slt.
  - Funct3=110: or.
  - Funct3=111: and.
- Any other Funct3 in EXECR, EXECI or BRANCH: no strobes are asserted that cycle, and the next state is TRAP.
- TRAP
  - Illegal=1 and all strobes are 0.
  - The FSM stays in TRAP until reset.

## Timing
- Reset:
  - reset_n low forces State=FETCH asynchronously and clears Illegal.
  - While reset_n is low, all strobes (MemRead, MemWrite, IRWrite, PCWrite, RegWrite) are 0.
  - After the first rising edge with reset_n high, the fetch request appears.
- Reset asserted mid-instruction aborts it immediately. No further strobes follow.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4.
- Each cycle with MemReady low in FETCH, MemREAD or MEMWRITE adds one cycle.
- MemReady is ignored in all states except FETCH, MEMREAD and MEMWRITE.
- Handshake: a request is held stable (same address select and same request signal) until it is accepted.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - Adds a 32-bit output InstRet.
  - InstRet resets to 0 and increments on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - The JAL→ALUWB path counts once, at ALUWB.
  - InstRet wraps from 0xFFFFFFFF to 0.
- CTRL_PERF_CNT_EN undefined: the port and the counter are absent.

## Test plan
- Release reset with MemReady=1 and fetch add (0110011, Funct3=000, Funct7b5=0) → State sequence 0,1,6,8,0; RegWrite is asserted only in state 8; ALUControl=000 in EXECR.
- lw with MemReady held low for 2 cycles in MEMREAD → MemRead and AdrSrc=1 are held for 3 cycles; total 7 cycles; RegWrite=1 with ResultSrc=01.
- beq with Zero=0, then bne with Zero=0 → PCWrite=0 in the first BRANCH, 1 in the second; each instruction takes 3 cycles.
- Opcode 1110011 → TRAP after DECODE; Illegal=1 and stays high; no strobes; a reset_n pulse returns the FSM to FETCH with Illegal=0.
- Assert reset_n low during MEMWRITE → State=0 and MemWrite=0 asynchronously, before the next edge.
- With CTRL_PERF_CNT_EN: execute sw, jal, sub → InstRet=3.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle RV32I-subset core (fetch/decode/execute/mem/writeback).
// Define CTRL_PERF_CNT_EN to add the 32-bit InstRet retired-instruction counter output.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  Opcode,
    input  logic [2:0]  Funct3,
    input  logic        Funct7b5,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic        Illegal,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] InstRet,
`endif
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_started;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_adrSrc;
    logic       w_irWrite;
    logic       w_pcWrite;
    logic       w_regWrite;
    logic [1:0] w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [2:0] w_aluControl;
    logic [1:0] w_resultSrc;
    logic [2:0] w_aluDecoded;
    logic       w_aluOk;

    // r_started holds the FSM idle for one edge after reset so the fetch request starts on a clean edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (r_started) begin
                r_state <= w_next;
            end
        end
    end

    always_comb begin
        w_aluDecoded = 3'b000;
        w_aluOk      = 1'b1;
        case (Funct3)
            3'b000:  w_aluDecoded = (r_state == S_EXECR && Funct7b5) ? 3'b001 : 3'b000;
            3'b010:  w_aluDecoded = 3'b101;
            3'b110:  w_aluDecoded = 3'b011;
            3'b111:  w_aluDecoded = 3'b010;
            default: w_aluOk      = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_memRead    = 1'b0;
        w_memWrite   = 1'b0;
        w_adrSrc     = 1'b0;
        w_irWrite    = 1'b0;
        w_pcWrite    = 1'b0;
        w_regWrite   = 1'b0;
        w_aluSrcA    = 2'b00;
        w_aluSrcB    = 2'b00;
        w_aluControl = 3'b000;
        w_resultSrc  = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memRead   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_resultSrc = 2'b10;
                w_irWrite   = MemReady;
                w_pcWrite   = MemReady;
                if (MemReady) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b01;
                case (Opcode)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    default:                w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_next    = Opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_memRead = 1'b1;
                w_adrSrc  = 1'b1;
                if (MemReady) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_resultSrc = 2'b01;
                w_regWrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_memWrite = 1'b1;
                w_adrSrc   = 1'b1;
                if (MemReady) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECR: begin
                w_aluSrcA    = 2'b10;
                w_aluSrcB    = 2'b00;
                w_aluControl = w_aluDecoded;
                w_next       = w_aluOk ? S_ALUWB : S_TRAP;
            end
            S_EXECI: begin
                w_aluSrcA    = 2'b10;
                w_aluSrcB    = 2'b01;
                w_aluControl = w_aluDecoded;
                w_next       = w_aluOk ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_aluSrcA    = 2'b10;
                w_aluControl = 3'b001;
                case (Funct3)
                    3'b000: begin
                        w_pcWrite = Zero;
                        w_next    = S_FETCH;
                    end
                    3'b001: begin
                        w_pcWrite = !Zero;
                        w_next    = S_FETCH;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_JAL: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b10;
                w_pcWrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    // Strobes stay low through reset and the first edge after it, so no stray request escapes.
    assign MemRead    = w_memRead  & r_started;
    assign MemWrite   = w_memWrite & r_started;
    assign AdrSrc     = w_adrSrc;
    assign IRWrite    = w_irWrite  & r_started;
    assign PCWrite    = w_pcWrite  & r_started;
    assign RegWrite   = w_regWrite & r_started;
    assign ALUSrcA    = w_aluSrcA;
    assign ALUSrcB    = w_aluSrcB;
    assign ALUControl = w_aluControl;
    assign ResultSrc  = w_resultSrc;
    assign Illegal    = (r_state == S_TRAP);
    assign State      = r_state;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_instRet;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instRet <= 32'd0;
        end else if (r_started && w_next == S_FETCH &&
                     (r_state == S_MEMWB || r_state == S_MEMWRITE ||
                      r_state == S_ALUWB || r_state == S_BRANCH)) begin
            r_instRet <= r_instRet + 32'd1;
        end
    end

    assign InstRet = r_instRet;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl; directed per-cycle expectations
// are queued by the stimulus and compared by a negedge monitor.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset_n;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic        Funct7b5;
    logic        Zero;
    logic        MemReady;
    logic        MemRead;
    logic        MemWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic        Illegal;
    logic [3:0]  State;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] InstRet;
`endif

    multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Opcode     (Opcode),
        .Funct3     (Funct3),
        .Funct7b5   (Funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .Illegal    (Illegal),
`ifdef CTRL_PERF_CNT_EN
        .InstRet    (InstRet),
`endif
        .State      (State)
    );

    // Observed vector: {State, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, A, B, ALU, ResultSrc, Illegal}
    localparam logic [19:0] MASK_FULL = 20'hFFFFF;
    localparam logic [19:0] MASK_STRB = 20'hFFC01;
    localparam logic [19:0] MASK_NALU = 20'hFFFC7;

    typedef struct {
        string       name;
        logic [19:0] exp;
        logic [19:0] mask;
        bit          chkRet;
        logic [31:0] ret;
    } sbEntry_t;

    sbEntry_t    sbQ[$];
    sbEntry_t    curEntry;
    logic [19:0] actVec;
    int          errors = 0;
    int          checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] ev(input logic [3:0] st, input logic [5:0] strb,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [1:0] rs,
                                       input logic ill);
        return {st, strb, a, b, alu, rs, ill};
    endfunction

    // Drive one cycle of inputs, queue what the DUT must show this cycle, then step to the next edge.
    task automatic applyStimulus(input string nm, input logic z, input logic rdy,
                                 input logic [19:0] e, input logic [19:0] m = MASK_FULL,
                                 input bit chk = 1'b0, input logic [31:0] ret = 32'd0);
        sbEntry_t ent;
        Zero     = z;
        MemReady = rdy;
        ent.name   = nm;
        ent.exp    = e;
        ent.mask   = m;
        ent.chkRet = chk;
        ent.ret    = ret;
        sbQ.push_back(ent);
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        Opcode   = op;
        Funct3   = f3;
        Funct7b5 = f7;
    endtask

    task automatic fetchDecode(input string tag);
        applyStimulus({tag, "_fetch"}, 1'b0, 1'b1, ev(4'd0, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0));
        applyStimulus({tag, "_decode"}, 1'b0, 1'b0, ev(4'd1, 6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0));
    endtask

    task automatic pulseReset(input string tag);
        reset_n = 1'b0;
        applyStimulus({tag, "_inreset"}, 1'b0, 1'b1, ev(4'd0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), MASK_STRB);
        reset_n = 1'b1;
        applyStimulus({tag, "_released"}, 1'b0, 1'b1, ev(4'd0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), MASK_STRB);
    endtask

    task automatic checkOutput(input sbEntry_t ent);
        actVec = {State, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Illegal};
        checks++;
        if ((actVec & ent.mask) !== (ent.exp & ent.mask)) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h (mask %05h)", ent.name, actVec, ent.exp, ent.mask);
        end
`ifdef CTRL_PERF_CNT_EN
        if (ent.chkRet) begin
            checks++;
            if (InstRet !== ent.ret) begin
                errors++;
                $display("[TB] FAIL %s_instret: got %0d expected %0d", ent.name, InstRet, ent.ret);
            end
        end
`endif
    endtask

    // Monitor: compares every queued expectation away from the rising edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                curEntry = sbQ.pop_front();
                checkOutput(curEntry);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        reset_n = 1'b1;
        setInstr(7'b0000000, 3'b000, 1'b0);
        Zero     = 1'b0;
        MemReady = 1'b1;
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        pulseReset("por");

        // add: 0,1,6,8
        setInstr(7'b0110011, 3'b000, 1'b0);
        fetchDecode("add");
        applyStimulus("add_execr", 1'b0, 1'b1, ev(4'd6, 6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0));
        applyStimulus("add_aluwb", 1'b0, 1'b1, ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));

        // lw with two wait states in MEMREAD, MemReady ignored elsewhere
        setInstr(7'b0000011, 3'b010, 1'b0);
        fetchDecode("lw");
        applyStimulus("lw_memadr", 1'b0, 1'b0, ev(4'd2, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0));
        applyStimulus("lw_memread0", 1'b0, 1'b0, ev(4'd3, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        applyStimulus("lw_memread1", 1'b0, 1'b0, ev(4'd3, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        applyStimulus("lw_memread2", 1'b0, 1'b1, ev(4'd3, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        applyStimulus("lw_memwb", 1'b0, 1'b0, ev(4'd4, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0));

        setInstr(7'b1100011, 3'b000, 1'b0);
        fetchDecode("beq");
        applyStimulus("beq_z0", 1'b0, 1'b1, ev(4'd9, 6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0));
        setInstr(7'b1100011, 3'b001, 1'b0);
        fetchDecode("bne");
        applyStimulus("bne_z0", 1'b0, 1'b1, ev(4'd9, 6'b000010, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0));
        setInstr(7'b1100011, 3'b000, 1'b0);
        fetchDecode("beq1");
        applyStimulus("beq_z1", 1'b1, 1'b1, ev(4'd9, 6'b000010, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0));

        // addi with bit 30 set must still add
        setInstr(7'b0010011, 3'b000, 1'b1);
        fetchDecode("addi");
        applyStimulus("addi_execi", 1'b0, 1'b1, ev(4'd7, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0));
        applyStimulus("addi_aluwb", 1'b0, 1'b1, ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        setInstr(7'b0010011, 3'b110, 1'b0);
        fetchDecode("ori");
        applyStimulus("ori_execi", 1'b0, 1'b1, ev(4'd7, 6'b000000, 2'b10, 2'b01, 3'b011, 2'b00, 1'b0));
        applyStimulus("ori_aluwb", 1'b0, 1'b1, ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        setInstr(7'b0110011, 3'b010, 1'b0);
        fetchDecode("slt");
        applyStimulus("slt_execr", 1'b0, 1'b1, ev(4'd6, 6'b000000, 2'b10, 2'b00, 3'b101, 2'b00, 1'b0));
        applyStimulus("slt_aluwb", 1'b0, 1'b1, ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        setInstr(7'b0110011, 3'b111, 1'b0);
        fetchDecode("and");
        applyStimulus("and_execr", 1'b0, 1'b1, ev(4'd6, 6'b000000, 2'b10, 2'b00, 3'b010, 2'b00, 1'b0));
        applyStimulus("and_aluwb", 1'b0, 1'b1, ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));

        // unsupported Funct3 in EXECR traps
        setInstr(7'b0110011, 3'b001, 1'b0);
        fetchDecode("badf3");
        applyStimulus("badf3_execr", 1'b0, 1'b1, ev(4'd6, 6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0), MASK_NALU);
        applyStimulus("badf3_trap0", 1'b0, 1'b1, ev(4'd15, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
        applyStimulus("badf3_trap1", 1'b0, 1'b0, ev(4'd15, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
        pulseReset("rst1");

        // unsupported opcode traps and stays there until reset
        setInstr(7'b1110011, 3'b000, 1'b0);
        fetchDecode("ecall");
        applyStimulus("ecall_trap0", 1'b0, 1'b1, ev(4'd15, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
        applyStimulus("ecall_trap1", 1'b1, 1'b0, ev(4'd15, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
        applyStimulus("ecall_trap2", 1'b0, 1'b1, ev(4'd15, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
        pulseReset("rst2");

        // sw with a fetch wait state, then reset asserted while MEMWRITE is waiting
        setInstr(7'b0100011, 3'b010, 1'b0);
        applyStimulus("sw_fetchwait", 1'b0, 1'b0, ev(4'd0, 6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0));
        fetchDecode("sw");
        applyStimulus("sw_memadr", 1'b0, 1'b1, ev(4'd2, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0));
        applyStimulus("sw_memwrite", 1'b0, 1'b0, ev(4'd5, 6'b011000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        pulseReset("rst3");

        // sw, jal, sub: retired-instruction count reaches 3
        setInstr(7'b0100011, 3'b010, 1'b0);
        applyStimulus("p_sw_fetch", 1'b0, 1'b1, ev(4'd0, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0), MASK_FULL, 1'b1, 32'd0);
        applyStimulus("p_sw_decode", 1'b0, 1'b1, ev(4'd1, 6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0));
        applyStimulus("p_sw_memadr", 1'b0, 1'b1, ev(4'd2, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0));
        applyStimulus("p_sw_memwrite", 1'b0, 1'b1, ev(4'd5, 6'b011000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        setInstr(7'b1101111, 3'b000, 1'b0);
        applyStimulus("p_jal_fetch", 1'b0, 1'b1, ev(4'd0, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0), MASK_FULL, 1'b1, 32'd1);
        applyStimulus("p_jal_decode", 1'b0, 1'b1, ev(4'd1, 6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0));
        applyStimulus("p_jal_jal", 1'b0, 1'b1, ev(4'd10, 6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0));
        applyStimulus("p_jal_aluwb", 1'b0, 1'b1, ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), MASK_FULL, 1'b1, 32'd1);
        setInstr(7'b0110011, 3'b000, 1'b1);
        applyStimulus("p_sub_fetch", 1'b0, 1'b1, ev(4'd0, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0), MASK_FULL, 1'b1, 32'd2);
        applyStimulus("p_sub_decode", 1'b0, 1'b1, ev(4'd1, 6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0));
        applyStimulus("p_sub_execr", 1'b0, 1'b1, ev(4'd6, 6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0));
        applyStimulus("p_sub_aluwb", 1'b0, 1'b1, ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
        applyStimulus("p_end_fetch", 1'b0, 1'b0, ev(4'd0, 6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0), MASK_FULL, 1'b1, 32'd3);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
